// File: rtl/mem_bridge_pkg.sv
// Shared definitions for the memory bridge: FSM encoding and strobe sizing.
package mem_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      D_ADDR,
      D_DATA,
      I_ADDR,
      I_DATA
   } state_t;

   localparam int unsigned BYTE_W = 8;

   // Number of byte enables for a data bus of the given width.
   function automatic int unsigned strb_width(input int unsigned data_w);
      return data_w / BYTE_W;
   endfunction

endpackage

// File: rtl/mem_bridge_side_hold.sv
// Per-side completion flag and read-data hold register.
module side_hold #(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              set,
   input  logic              clear,
   input  logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic [DATA_W-1:0] hold
);

   // Done flag: clear wins over set; hold captures bus data on completion.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         done <= 1'b0;
         hold <= '0;
      end else begin
         if (clear) begin
            done <= 1'b0;
         end else if (set) begin
            done <= 1'b1;
         end
         if (set) begin
            hold <= rdata;
         end
      end
   end

endmodule

// File: rtl/mem_bridge.sv
// Bridge from split inst/data core ports to a single-outstanding bus.
module mem_bridge
   import mem_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          inst_req,
   input  logic [ADDR_W-1:0]             inst_addr,
   output logic [DATA_W-1:0]             inst_rdata,
   output logic                          inst_stall,
   input  logic                          data_req,
   input  logic                          data_wr,
   input  logic [ADDR_W-1:0]             data_addr,
   input  logic [DATA_W-1:0]             data_wdata,
   input  logic [strb_width(DATA_W)-1:0] data_wstrb,
   output logic [DATA_W-1:0]             data_rdata,
   output logic                          data_stall,
   input  logic                          pipe_stall,
   output logic                          bus_req,
   output logic                          bus_wr,
   output logic [ADDR_W-1:0]             bus_addr,
   output logic [DATA_W-1:0]             bus_wdata,
   output logic [strb_width(DATA_W)-1:0] bus_wstrb,
   input  logic                          bus_addr_ok,
   input  logic                          bus_data_ok,
   input  logic [DATA_W-1:0]             bus_rdata
);

   localparam int unsigned STRB_W = strb_width(DATA_W);

   state_t              state;
   state_t              state_next;
   logic [ADDR_W-1:0]   addr_q;
   logic                wr_q;
   logic [STRB_W-1:0]   strb_q;
   logic [DATA_W-1:0]   wdata_q;
   logic                inst_done;
   logic                data_done;
   logic [DATA_W-1:0]   inst_hold;
   logic [DATA_W-1:0]   data_hold;
   logic                inst_pend;
   logic                data_pend;
   logic                inst_fin;
   logic                data_fin;
   logic                hold_clear;

   assign inst_pend  = inst_req & ~inst_done;
   assign data_pend  = data_req & ~data_done;
   assign hold_clear = ~pipe_stall;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: data side has priority when both are pending.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (data_pend) begin
               state_next = D_ADDR;
            end else if (inst_pend) begin
               state_next = I_ADDR;
            end
         end
         D_ADDR: if (bus_addr_ok) state_next = D_DATA;
         I_ADDR: if (bus_addr_ok) state_next = I_DATA;
         D_DATA: if (bus_data_ok) state_next = IDLE;
         I_DATA: if (bus_data_ok) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Request fields are latched in IDLE so the bus sees them stable while bus_req is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wr_q    <= 1'b0;
         strb_q  <= '0;
         wdata_q <= '0;
      end else if (state == IDLE) begin
         if (data_pend) begin
            addr_q  <= data_addr;
            wr_q    <= data_wr;
            strb_q  <= data_wr ? data_wstrb : '0;
            wdata_q <= data_wdata;
         end else begin
            addr_q  <= inst_addr;
            wr_q    <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
         end
      end
   end

   // Output decode: bus drive, completion detect, stalls and read-data muxing.
   always_comb begin
      bus_req    = (state == D_ADDR) || (state == I_ADDR);
      bus_addr   = addr_q;
      bus_wr     = bus_req & wr_q;
      bus_wstrb  = bus_req ? strb_q : '0;
      bus_wdata  = wdata_q;
      inst_fin   = (state == I_DATA) & bus_data_ok;
      data_fin   = (state == D_DATA) & bus_data_ok;
      inst_stall = inst_req & ~(inst_done | inst_fin);
      data_stall = data_req & ~(data_done | data_fin);
      inst_rdata = inst_fin ? bus_rdata : inst_hold;
      data_rdata = data_fin ? bus_rdata : data_hold;
   end

   side_hold #(.DATA_W(DATA_W)) u_inst_hold (
      .clk   (clk),
      .rst   (rst),
      .set   (inst_fin),
      .clear (hold_clear),
      .rdata (bus_rdata),
      .done  (inst_done),
      .hold  (inst_hold)
   );

   side_hold #(.DATA_W(DATA_W)) u_data_hold (
      .clk   (clk),
      .rst   (rst),
      .set   (data_fin),
      .clear (hold_clear),
      .rdata (bus_rdata),
      .done  (data_done),
      .hold  (data_hold)
   );

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: stimulus queues expectations, monitors compare.
module tb_mem_bridge;

   typedef struct {
      logic [31:0] addr;
      logic        wr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      bit          chk_w;
   } bus_exp_t;

   typedef struct {
      bit          chk;
      logic [31:0] rdata;
   } dat_exp_t;

   logic        clk;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic [31:0] inst_rdata;
   logic        inst_stall;
   logic        data_req;
   logic        data_wr;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic [3:0]  data_wstrb;
   logic [31:0] data_rdata;
   logic        data_stall;
   logic        pipe_stall;
   logic        bus_req;
   logic        bus_wr;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wstrb;
   logic        bus_addr_ok;
   logic        bus_data_ok;
   logic [31:0] bus_rdata;

   logic        xstall;
   logic        slave_en;
   logic        s_addr_ok, s_data_ok, m_addr_ok, m_data_ok;
   logic [31:0] s_rdata, m_rdata;
   int          addr_dly, data_dly;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          bus_req_cycles = 0;
   int          i_cyc = 0;
   int          d_cyc = 0;

   bus_exp_t    bus_q[$];
   logic [31:0] iq[$];
   dat_exp_t    dq[$];
   logic [31:0] rdata_q[$];

   assign pipe_stall  = inst_stall | data_stall | xstall;
   assign bus_addr_ok = slave_en ? s_addr_ok : m_addr_ok;
   assign bus_data_ok = slave_en ? s_data_ok : m_data_ok;
   assign bus_rdata   = slave_en ? s_rdata : m_rdata;

   mem_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .inst_req    (inst_req),
      .inst_addr   (inst_addr),
      .inst_rdata  (inst_rdata),
      .inst_stall  (inst_stall),
      .data_req    (data_req),
      .data_wr     (data_wr),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_wstrb  (data_wstrb),
      .data_rdata  (data_rdata),
      .data_stall  (data_stall),
      .pipe_stall  (pipe_stall),
      .bus_req     (bus_req),
      .bus_wr      (bus_wr),
      .bus_addr    (bus_addr),
      .bus_wdata   (bus_wdata),
      .bus_wstrb   (bus_wstrb),
      .bus_addr_ok (bus_addr_ok),
      .bus_data_ok (bus_data_ok),
      .bus_rdata   (bus_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic exp_bus(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, input bit cw);
      bus_exp_t e;
      e.addr = a; e.wr = w; e.strb = s; e.wdata = d; e.chk_w = cw;
      bus_q.push_back(e);
   endtask

   task automatic exp_data(input bit c, input logic [31:0] d);
      dat_exp_t e;
      e.chk = c; e.rdata = d;
      dq.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for a cycle where the core may advance, then return just after that edge.
   task automatic wait_advance(input string name, input int maxc);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (pipe_stall && n < maxc);
      chk({name, "_timeout"}, {63'd0, pipe_stall}, 64'd0);
      tick();
   endtask

   // Bus slave: programmable addr_ok / data_ok delays, read data from rdata_q.
   initial begin
      int sst;
      int wcnt;
      sst = 0; wcnt = 0;
      s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         s_addr_ok = 1'b0;
         s_data_ok = 1'b0;
         s_rdata   = $urandom;
         if (rst) begin
            sst = 0;
         end else begin
            if (sst == 0 && bus_req) begin
               wcnt = addr_dly;
               sst  = 1;
            end else if (sst == 2) begin
               if (wcnt == 0) begin
                  s_data_ok = 1'b1;
                  s_rdata   = (rdata_q.size() > 0) ? rdata_q.pop_front() : '0;
                  sst       = 0;
               end else begin
                  wcnt--;
               end
            end
            if (sst == 1) begin
               if (wcnt == 0) begin
                  s_addr_ok = 1'b1;
                  wcnt      = data_dly;
                  sst       = 2;
               end else begin
                  wcnt--;
               end
            end
         end
      end
   end

   // Monitor: bus request fields, request drop after accept, core-side completions.
   initial begin
      bit prev_accept;
      bit prev_istall;
      bit prev_dstall;
      prev_accept = 0; prev_istall = 0; prev_dstall = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (prev_accept) chk("bus_req_drop", {63'd0, bus_req}, 64'd0);
            if (bus_req) begin
               bus_req_cycles++;
               if (bus_q.size() == 0) begin
                  chk("bus_req_unexpected", {63'd0, bus_req}, 64'd0);
               end else begin
                  chk("bus_addr", {32'd0, bus_addr}, {32'd0, bus_q[0].addr});
                  chk("bus_wr", {63'd0, bus_wr}, {63'd0, bus_q[0].wr});
                  chk("bus_wstrb", {60'd0, bus_wstrb}, {60'd0, bus_q[0].strb});
                  if (bus_q[0].chk_w) chk("bus_wdata", {32'd0, bus_wdata}, {32'd0, bus_q[0].wdata});
                  if (bus_addr_ok) void'(bus_q.pop_front());
               end
            end
            if (inst_req && !inst_stall && prev_istall) begin
               i_cyc = cyc;
               if (iq.size() == 0) chk("inst_done_unexpected", {63'd0, inst_stall}, 64'd1);
               else chk("inst_rdata", {32'd0, inst_rdata}, {32'd0, iq.pop_front()});
            end
            if (data_req && !data_stall && prev_dstall) begin
               dat_exp_t e;
               d_cyc = cyc;
               if (dq.size() == 0) begin
                  chk("data_done_unexpected", {63'd0, data_stall}, 64'd1);
               end else begin
                  e = dq.pop_front();
                  if (e.chk) chk("data_rdata", {32'd0, data_rdata}, {32'd0, e.rdata});
               end
            end
         end
         prev_accept = bus_req & bus_addr_ok;
         prev_istall = inst_stall;
         prev_dstall = data_stall;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Directed stimulus.
   initial begin
      int n;
      int cnt0;
      rst = 1'b1; xstall = 1'b0; slave_en = 1'b1;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
      addr_dly = 0; data_dly = 0;
      inst_req = 1'b0; inst_addr = '0;
      data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0;

      // Reset state
      tick(); tick();
      @(negedge clk);
      chk("rst_bus_req", {63'd0, bus_req}, 64'd0);
      chk("rst_bus_wr", {63'd0, bus_wr}, 64'd0);
      chk("rst_bus_wstrb", {60'd0, bus_wstrb}, 64'd0);
      chk("rst_inst_rdata", {32'd0, inst_rdata}, 64'd0);
      chk("rst_data_rdata", {32'd0, data_rdata}, 64'd0);
      chk("rst_inst_stall", {63'd0, inst_stall}, 64'd0);
      chk("rst_data_stall", {63'd0, data_stall}, 64'd0);
      tick();
      rst = 1'b0;
      tick();

      // Single fetch at minimum latency
      exp_bus(32'hBFC00000, 1'b0, 4'h0, 32'h0, 0);
      rdata_q.push_back(32'h24080001);
      iq.push_back(32'h24080001);
      inst_addr = 32'hBFC00000; inst_req = 1'b1;
      @(negedge clk);
      chk("fetch_stall_c0", {63'd0, inst_stall}, 64'd1);
      chk("fetch_busreq_c0", {63'd0, bus_req}, 64'd0);
      @(negedge clk);
      chk("fetch_stall_c1", {63'd0, inst_stall}, 64'd1);
      chk("fetch_busreq_c1", {63'd0, bus_req}, 64'd1);
      @(negedge clk);
      chk("fetch_stall_c2", {63'd0, inst_stall}, 64'd0);
      chk("fetch_rdata_c2", {32'd0, inst_rdata}, 64'h24080001);
      tick();
      inst_req = 1'b0;
      tick();

      // Collision: data load served first, then fetch
      exp_bus(32'h80000010, 1'b0, 4'h0, 32'h0, 0);
      exp_bus(32'hBFC00004, 1'b0, 4'h0, 32'h0, 0);
      rdata_q.push_back(32'h11112222);
      rdata_q.push_back(32'h33334444);
      exp_data(1, 32'h11112222);
      iq.push_back(32'h33334444);
      inst_addr = 32'hBFC00004; inst_req = 1'b1;
      data_addr = 32'h80000010; data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0;
      wait_advance("collision", 40);
      inst_req = 1'b0; data_req = 1'b0;
      chk("collision_order", {63'd0, (d_cyc < i_cyc)}, 64'd1);
      tick();

      // Full-word store
      exp_bus(32'h80000020, 1'b1, 4'hF, 32'hDEADBEEF, 1);
      rdata_q.push_back(32'h0);
      exp_data(0, 32'h0);
      data_addr = 32'h80000020; data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF;
      data_wr = 1'b1; data_req = 1'b1;
      wait_advance("store_full", 40);
      data_req = 1'b0;
      tick();

      // Partial store
      exp_bus(32'h80000024, 1'b1, 4'h3, 32'h0000CAFE, 1);
      rdata_q.push_back(32'h0);
      exp_data(0, 32'h0);
      data_addr = 32'h80000024; data_wdata = 32'h0000CAFE; data_wstrb = 4'h3;
      data_wr = 1'b1; data_req = 1'b1;
      wait_advance("store_part", 40);
      data_req = 1'b0;
      tick();

      // Load with strobes presented: bus strobes must be zero
      exp_bus(32'h80000028, 1'b0, 4'h0, 32'h0, 0);
      rdata_q.push_back(32'h12345678);
      exp_data(1, 32'h12345678);
      data_addr = 32'h80000028; data_wstrb = 4'hF; data_wr = 1'b0; data_req = 1'b1;
      wait_advance("load_strb", 40);
      data_req = 1'b0; data_wstrb = 4'h0;
      tick();

      // Fetch completes under external stall: result held, no re-issue
      xstall = 1'b1;
      exp_bus(32'hBFC00008, 1'b0, 4'h0, 32'h0, 0);
      rdata_q.push_back(32'hAAAA5555);
      iq.push_back(32'hAAAA5555);
      inst_addr = 32'hBFC00008; inst_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (inst_stall && n < 40);
      chk("hold_fetch_timeout", {63'd0, inst_stall}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_stall", {63'd0, inst_stall}, 64'd0);
         chk("hold_rdata", {32'd0, inst_rdata}, 64'hAAAA5555);
      end
      tick();
      xstall = 1'b0;
      exp_bus(32'hBFC0000C, 1'b0, 4'h0, 32'h0, 0);
      rdata_q.push_back(32'h5555AAAA);
      iq.push_back(32'h5555AAAA);
      tick();
      inst_addr = 32'hBFC0000C;
      wait_advance("hold_next", 40);
      inst_req = 1'b0;
      tick();

      // Delayed address acceptance: request held for 4 cycles plus the accept cycle
      addr_dly = 4; data_dly = 2;
      cnt0 = bus_req_cycles;
      exp_bus(32'h80000040, 1'b0, 4'h0, 32'h0, 0);
      rdata_q.push_back(32'hFEEDFACE);
      exp_data(1, 32'hFEEDFACE);
      data_addr = 32'h80000040; data_wr = 1'b0; data_req = 1'b1;
      wait_advance("addr_delay", 60);
      data_req = 1'b0;
      chk("addr_delay_req_cycles", 64'(bus_req_cycles - cnt0), 64'd5);
      addr_dly = 0;
      tick();

      // Reset during I_DATA, late data_ok after release is ignored
      data_dly = 10;
      exp_bus(32'hBFC00010, 1'b0, 4'h0, 32'h0, 0);
      inst_addr = 32'hBFC00010; inst_req = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(bus_req && bus_addr_ok) && n < 40);
      chk("rst_mid_accept_timeout", {63'd0, bus_addr_ok}, 64'd1);
      tick();
      slave_en = 1'b0; rst = 1'b1; inst_req = 1'b0;
      #1;
      chk("rst_mid_bus_req", {63'd0, bus_req}, 64'd0);
      tick(); tick();
      rst = 1'b0;
      m_data_ok = 1'b1; m_rdata = 32'h99999999;
      @(negedge clk);
      chk("late_ok_bus_req", {63'd0, bus_req}, 64'd0);
      chk("late_ok_inst_rdata", {32'd0, inst_rdata}, 64'd0);
      tick();
      m_data_ok = 1'b0;
      @(negedge clk);
      chk("late_ok_hold", {32'd0, inst_rdata}, 64'd0);
      tick();
      slave_en = 1'b1; data_dly = 0;
      exp_bus(32'hBFC00014, 1'b0, 4'h0, 32'h0, 0);
      rdata_q.push_back(32'h0BADF00D);
      iq.push_back(32'h0BADF00D);
      inst_addr = 32'hBFC00014; inst_req = 1'b1;
      @(negedge clk);
      chk("post_rst_no_done", {63'd0, inst_stall}, 64'd1);
      wait_advance("post_rst_fetch", 40);
      inst_req = 1'b0;
      tick(); tick();

      chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
      chk("iq_empty", 64'(iq.size()), 64'd0);
      chk("dq_empty", 64'(dq.size()), 64'd0);
      chk("rdata_q_empty", 64'(rdata_q.size()), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
